// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests
// onto a single byte-wide bus, assembling read bytes little-endian.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e            state_q, state_d;
  logic              is_if_q, is_if_d;    // current op serves the fetch port
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;            // byte count of current op
  logic [2:0]        iss_q, iss_d;        // next byte index to put on the bus
  logic [2:0]        cap_q, cap_d;        // next byte index to capture
  logic              a_vld_q, a_vld_d;    // mem_a carries a read address this cycle
  logic              d_vld_q, d_vld_d;    // mem_din carries the byte for last cycle's address
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;
  logic [31:0]       cap_word;

  function automatic logic [2:0] nbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Assembly buffer with the byte currently on mem_din merged in at cap_q.
  always_comb begin
    cap_word = buf_q;
    cap_word[{cap_q[1:0], 3'b000} +: 8] = mem_din;
  end

  // Next-state and registered-output logic for the bus sequencer.
  always_comb begin
    state_d    = state_q;
    is_if_d    = is_if_q;
    base_d     = base_q;
    n_d        = n_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    a_vld_d    = a_vld_q;
    d_vld_d    = d_vld_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = 1'b0;
    mem_dout_d = mem_dout_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      IDLE: begin
        mem_a_d    = '0;
        mem_dout_d = '0;
        a_vld_d    = 1'b0;
        d_vld_d    = 1'b0;
        // No grant in a done cycle, so a queued fetch starts one cycle after ls_done.
        if (rdy_in && !if_done_q && !ls_done_q) begin
          if (ls_req) begin
            is_if_d = 1'b0;
            base_d  = ls_addr;
            n_d     = nbytes(ls_size);
            wdata_d = ls_wdata;
            iss_d   = 3'd1;
            cap_d   = 3'd0;
            buf_d   = '0;
            mem_a_d = ls_addr;
            if (ls_wr) begin
              state_d    = WRITE;
              mem_wr_d   = 1'b1;
              mem_dout_d = ls_wdata[7:0];
            end else begin
              state_d = READ;
              a_vld_d = 1'b1;
            end
          end else if (if_req && !if_abort) begin
            state_d = READ;
            is_if_d = 1'b1;
            base_d  = if_addr;
            n_d     = 3'd4;
            iss_d   = 3'd1;
            cap_d   = 3'd0;
            buf_d   = '0;
            mem_a_d = if_addr;
            a_vld_d = 1'b1;
          end
        end
      end
      READ: begin
        if (is_if_q && if_abort) begin
          state_d = IDLE;
          mem_a_d = '0;
          a_vld_d = 1'b0;
          d_vld_d = 1'b0;
        end else if (!rdy_in) begin
          // Drop the in-flight byte and park the bus on the first uncaptured
          // address; the resume cycle then counts as its issue cycle.
          d_vld_d = 1'b0;
          a_vld_d = 1'b1;
          mem_a_d = base_q + ADDR_W'(cap_q);
          iss_d   = cap_q + 3'd1;
        end else begin
          d_vld_d = a_vld_q;
          if (d_vld_q) begin
            buf_d = cap_word;
            cap_d = cap_q + 3'd1;
          end
          if (d_vld_q && (cap_q + 3'd1 == n_q)) begin
            state_d = IDLE;
            mem_a_d = '0;
            a_vld_d = 1'b0;
            d_vld_d = 1'b0;
            if (is_if_q) begin
              if_data_d = cap_word;
              if_done_d = 1'b1;
            end else begin
              ls_rdata_d = cap_word;
              ls_done_d  = 1'b1;
            end
          end else if (iss_q < n_q) begin
            mem_a_d = base_q + ADDR_W'(iss_q);
            iss_d   = iss_q + 3'd1;
            a_vld_d = 1'b1;
          end else begin
            a_vld_d = 1'b0;
          end
        end
      end
      WRITE: begin
        if (!rdy_in) begin
          mem_wr_d = 1'b0;
        end else if (!mem_wr_q) begin
          // The strobe was suppressed by a pause: repeat the same byte.
          mem_wr_d = 1'b1;
        end else if (iss_q < n_q) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = base_q + ADDR_W'(iss_q);
          mem_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
          iss_d      = iss_q + 3'd1;
        end else begin
          state_d    = IDLE;
          mem_a_d    = '0;
          mem_dout_d = '0;
          ls_done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      is_if_q    <= 1'b0;
      base_q     <= '0;
      n_q        <= '0;
      iss_q      <= '0;
      cap_q      <= '0;
      a_vld_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      buf_q      <= '0;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      is_if_q    <= is_if_d;
      base_q     <= base_d;
      n_q        <= n_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      a_vld_q    <= a_vld_d;
      d_vld_q    <= d_vld_d;
      buf_q      <= buf_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q;
  assign mem_dout = mem_dout_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-addressed bus memory model.
module tb_mem_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_abort, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  // Unwritten locations read back as a fixed address-derived pattern.
  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  // Bus memory: one-cycle read latency, writes land only while the bus is owned.
  always @(posedge clk_in) begin
    mem_din <= rd(mem_a);
    if (mem_wr && rdy_in) mem[mem_a] = mem_dout;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    if_req = 0; if_addr = 0; if_abort = 0;
    ls_req = 0; ls_wr = 0; ls_size = 0; ls_addr = 0; ls_wdata = 0;
    mem[32'h10] = 8'h13; mem[32'h11] = 8'h37; mem[32'h12] = 8'h00; mem[32'h13] = 8'hEF;
    mem[32'h30000] = 8'h5C; mem[32'h202] = 8'h77;
    step(); step();
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_dones", {30'd0, if_done, ls_done}, 0);
    chk("rst_data", if_data | ls_rdata, 0);
    rst_in = 1'b0;
    step();

    // Word fetch at 0x10: addresses in cycles 1..4, done in cycle 6.
    if_req = 1; if_addr = 32'h10;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) chk("fetch_addr", mem_a, 32'h10 + 32'(c - 1));
      chk("fetch_nowr", {31'd0, mem_wr}, 0);
      chk("fetch_done", {31'd0, if_done}, (c == 6) ? 32'd1 : 32'd0);
    end
    chk("fetch_data", if_data, 32'hEF003713);
    if_req = 0;
    step();
    chk("fetch_pulse", {31'd0, if_done}, 0);

    // Half store at 0x200.
    ls_req = 1; ls_wr = 1; ls_size = 1; ls_addr = 32'h200; ls_wdata = 32'hAABBCCDD;
    step();
    chk("sth_b0", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h00, 8'hDD});
    chk("sth_a0", mem_a, 32'h200);
    step();
    chk("sth_b1", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h01, 8'hCC});
    chk("sth_nodone", {31'd0, ls_done}, 0);
    step();
    chk("sth_done", {30'd0, ls_done, mem_wr}, 32'd2);
    ls_req = 0; ls_wr = 0;
    step();
    chk("sth_mem", {8'd0, rd(32'h202), rd(32'h201), rd(32'h200)}, 32'h0077CCDD);

    // Simultaneous fetch and byte load: load first, fetch granted after ls_done.
    if_req = 1; if_addr = 32'h0;
    ls_req = 1; ls_wr = 0; ls_size = 0; ls_addr = 32'h30000;
    step();
    chk("sim_ld_addr", mem_a, 32'h30000);
    step();
    chk("sim_ld_wait", {31'd0, ls_done}, 0);
    step();
    chk("sim_ld_done", {31'd0, ls_done}, 1);
    chk("sim_ld_data", ls_rdata, 32'h0000005C);
    ls_req = 0;
    for (int c = 4; c <= 10; c++) begin
      step();
      if (c <= 5) chk("sim_f_a0", mem_a, 0);
      if (c >= 6 && c <= 8) chk("sim_f_addr", mem_a, 32'(c - 5));
      chk("sim_f_done", {31'd0, if_done}, (c == 10) ? 32'd1 : 32'd0);
    end
    chk("sim_f_data", if_data, 32'hA6A7A4A5);
    if_req = 0;
    step();

    // Pause for cycles 3..5 of a word fetch: byte 1 re-driven on resume.
    if_req = 1; if_addr = 32'h10;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 3) rdy_in = 0;
      if (c == 6) rdy_in = 1;
      if (c == 1) chk("pz_a0", mem_a, 32'h10);
      if (c == 2) chk("pz_a1", mem_a, 32'h11);
      if (c >= 6 && c <= 8) chk("pz_resume", mem_a, 32'h11 + 32'(c - 6));
      chk("pz_nowr", {31'd0, mem_wr}, 0);
      chk("pz_done", {31'd0, if_done}, (c == 10) ? 32'd1 : 32'd0);
    end
    chk("pz_data", if_data, 32'hEF003713);
    if_req = 0;
    step();

    // Abort in cycle 3 with a load waiting: load granted in cycle 4.
    if_req = 1; if_addr = 32'h10;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin
        ls_req = 1; ls_wr = 0; ls_size = 0; ls_addr = 32'h30000;
      end
      if (c == 3) if_abort = 1;
      if (c == 4) begin
        chk("ab_idle", mem_a, 0);
        if_abort = 0; if_req = 0;
      end
      if (c == 5) chk("ab_ld_addr", mem_a, 32'h30000);
      if (c == 7) begin
        chk("ab_ld_done", {31'd0, ls_done}, 1);
        chk("ab_ld_data", ls_rdata, 32'h0000005C);
        ls_req = 0;
      end
      chk("ab_no_ifdone", {31'd0, if_done}, 0);
    end
    chk("ab_ifdata_kept", if_data, 32'hEF003713);

    // Byte store with a pause on its strobe cycle: the byte is repeated.
    ls_req = 1; ls_wr = 1; ls_size = 0; ls_addr = 32'h400; ls_wdata = 32'h0000005A;
    step();
    rdy_in = 0;
    step();
    chk("wpz_gated", {31'd0, mem_wr}, 0);
    rdy_in = 1;
    step();
    chk("wpz_redo", {mem_wr, 15'd0, mem_a[15:0]}, {1'b1, 15'd0, 16'h0400});
    chk("wpz_nodone", {31'd0, ls_done}, 0);
    step();
    chk("wpz_done", {31'd0, ls_done}, 1);
    chk("wpz_mem", {24'd0, rd(32'h400)}, 32'h5A);
    ls_req = 0; ls_wr = 0;
    step();

    // Reset in the middle of a word store.
    ls_req = 1; ls_wr = 1; ls_size = 2; ls_addr = 32'h300; ls_wdata = 32'h11223344;
    step();
    step();
    chk("rw_b1", {mem_wr, 23'd0, mem_dout}, {1'b1, 23'd0, 8'h33});
    rst_in = 1;
    step();
    chk("rw_wr", {31'd0, mem_wr}, 0);
    chk("rw_a", mem_a, 0);
    chk("rw_nodone", {31'd0, ls_done}, 0);
    rst_in = 0; ls_req = 0; ls_wr = 0;
    step();
    chk("rw_idle_done", {31'd0, ls_done}, 0);
    chk("rw_mem", {16'd0, rd(32'h302), rd(32'h301)}, {16'd0, 8'h02 ^ 8'hA5, 8'h33});

    // Wrapping word store at 0xFFFFFFFF.
    ls_req = 1; ls_wr = 1; ls_size = 2; ls_addr = 32'hFFFFFFFF; ls_wdata = 32'hCAFEBABE;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) chk("wrap_a0", mem_a, 32'hFFFFFFFF);
      if (c >= 2 && c <= 4) chk("wrap_a", mem_a, 32'(c - 2));
      chk("wrap_wr", {31'd0, mem_wr}, (c <= 4) ? 32'd1 : 32'd0);
      chk("wrap_done", {31'd0, ls_done}, (c == 5) ? 32'd1 : 32'd0);
    end
    ls_req = 0; ls_wr = 0;
    step();

    // Wrapping word load reads the stored value back.
    ls_req = 1; ls_wr = 0; ls_size = 2; ls_addr = 32'hFFFFFFFF;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("wrld_done", {31'd0, ls_done}, (c == 6) ? 32'd1 : 32'd0);
    end
    chk("wrld_data", ls_rdata, 32'hCAFEBABE);
    ls_req = 0;
    step();

    // Half load zero-extends.
    ls_req = 1; ls_wr = 0; ls_size = 1; ls_addr = 32'h200;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("lh_done", {31'd0, ls_done}, (c == 4) ? 32'd1 : 32'd0);
    end
    chk("lh_data", ls_rdata, 32'h0000CCDD);
    ls_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller inside the CPU; the only driver of the CPU's memory bus (mem_a, mem_wr, mem_dout, mem_din).
- Arbitrates between the instruction-fetch port (32-bit reads) and the load/store port (1/2/4-byte reads and writes).
- Converts each request into consecutive single-byte bus cycles and assembles the returned bytes little-endian.
- Tolerates bus pauses (rdy_in low) and fetch aborts on branch redirect.

Parameters:
ADDR_W, 32, width of request and bus addresses

Ports:
clk_in  in  1  clock
rst_in  in  1  reset: synchronous, active-high
rdy_in  in  1  bus available; low = CPU paused, bus not owned
if_req  in  1  fetch request (level, held until if_done)
if_addr  in  ADDR_W  fetch byte address
if_abort  in  1  cancel any fetch in progress
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
ls_req  in  1  load/store request (level, held until ls_done)
ls_wr  in  1  1 = store, 0 = load
ls_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
ls_addr  in  ADDR_W  load/store byte address
ls_wdata  in  32  store data, low n bytes used
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended raw bytes
mem_din  in  8  byte read from bus (address registered one cycle earlier)
mem_dout  out  8  byte to write
mem_a  out  ADDR_W  bus address
mem_wr  out  1  write strobe

Behaviour:
- Reset values: state IDLE; all outputs 0. Reset mid-operation aborts the operation with no done pulse.
- All outputs are registered.
- States:
  - IDLE: drives mem_a=0, mem_wr=0.
  - READ / WRITE: n bytes, where n=1/2/4.
  - After the last byte, the controller returns to IDLE with the done pulse asserted in that cycle.
- Grant (IDLE, rdy_in=1):
  - ls_req has priority over if_req.
  - A port whose done is high this cycle is not granted.
  - An if_req whose if_abort is high is not granted.
  - Operands are latched at grant; requesters must still hold them stable until done.
- Bus timing:
  - Bus reads have 1-cycle latency: the byte for the address driven in cycle k appears on mem_din in cycle k+1.
- Read, granted in cycle 0:
  - Cycles 1..n drive mem_a = addr+i.
  - Byte i is captured in cycle i+2 into bits [8i+7:8i].
  - done and data are valid in cycle n+2. Word fetch: if_done in cycle 6.
- Write, granted in cycle 0:
  - Cycles 1..n drive mem_wr=1, mem_a=addr+i, mem_dout=ls_wdata[8i+7:8i].
  - ls_done in cycle n+1.
- Addresses: addr+i wraps modulo 2^ADDR_W. No alignment requirement.
- Read data: unused upper bytes of ls_rdata are 0. if_data and ls_rdata hold their last value until overwritten.
- rdy_in low:
  - All state and counters freeze.
  - mem_wr is forced to 0 at the output register.
  - Any in-flight read byte is discarded: its in-flight flag is cleared and the issue index rewinds to the capture index.
  - On the first cycle rdy_in is high again, the uncaptured byte's address is re-driven.
  - A write byte cycle during which rdy_in is low does not count and is repeated.
  - done pulses are never issued while rdy_in is low; they are delayed until rdy_in is high.
- if_abort high during a READ serving fetch: return to IDLE at the next edge with no if_done. if_data is unchanged. Abort never affects a load/store in progress.
- Simultaneous if_req and ls_req in IDLE: the load/store is served first; the fetch is granted the cycle after ls_done.

Test Plan:
- Word fetch: memory 0x10..0x13 = 13,37,00,EF; if_req with if_addr=0x10 in cycle 0 -> mem_a = 0x10..0x13 in cycles 1..4; if_done in cycle 6 with if_data=0xEF003713; no mem_wr.
- Store half: ls_wr=1, ls_size=1, ls_addr=0x200, ls_wdata=0xAABBCCDD -> mem_wr=1 with (0x200,DD) then (0x201,CC); ls_done in cycle 3; byte 0x202 untouched.
- Simultaneous requests: if_req (0x0) and byte load (0x30000) in the same cycle -> load bus cycles first, ls_done in cycle 3 with ls_rdata=0x000000xx; fetch issues 0x0 from cycle 4; if_done in cycle 10.
- Pause: rdy_in low for 3 cycles after byte 1 of a word fetch is issued -> after resume, mem_a re-drives addr+1; if_data is correct; if_done delayed by exactly 4 cycles (pause plus reissue); mem_wr stays 0 throughout.
- Abort: if_abort in cycle 3 of a fetch -> IDLE in cycle 4; no if_done; a pending ls_req is granted in cycle 4.
- Reset mid-write (after 2 of 4 bytes) -> next cycle mem_wr=0, mem_a=0, no ls_done; a fresh request afterwards completes normally; wrap case ls_addr=0xFFFFFFFF word -> bytes at 0xFFFFFFFF, 0, 1, 2.
